// File: rtl/cart_image_loader.sv
// cart_image_loader: copies one flash image slot into cartridge RAM, with the upper part of
// the image sent to a separate RAM window, then captures the header/flag bytes that follow
// the payload. After a settle delay it raises cart_ready.
// Optional build macro LOADER_CHECKSUM_EN: compares a 16-bit payload sum against the last two
// flag bytes (little-endian). With a mismatch, load_error is raised and cart_ready stays low.
//
// state  | meaning
// LOAD   | fetching payload bytes, one RAM write per accepted byte
// FLAGS  | fetching header bytes into flags_out, no RAM writes
// SETTLE | flash idle, counting 0..SETTLE_CYCLES
// DONE   | image ready (or checksum failed); holds until reload/reset
module cart_image_loader #(
  parameter int          IMAGE_BYTES   = 65536,
  parameter int          SPLIT_BYTES   = 32768,
  parameter logic [21:0] DEST_LO_BASE  = 22'h0,
  parameter logic [21:0] DEST_HI_BASE  = 22'h200000,
  parameter logic [23:0] FLASH_BASE    = 24'h200000,
  parameter int          SLOT_SHIFT    = 18,
  parameter int          SLOT_BITS     = 4,
  parameter int          FLAG_BYTES    = 4,
  parameter int          SETTLE_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    reload,
  input  logic [SLOT_BITS-1:0]    index,
  output logic                    rd_valid,
  output logic [23:0]             rd_addr,
  input  logic                    rd_ready,
  input  logic [7:0]              rd_data,
  output logic                    load_wren,
  output logic [21:0]             load_address,
  output logic [7:0]              load_write_data,
  output logic [8*FLAG_BYTES-1:0] flags_out,
  output logic                    cart_ready,
  output logic                    load_error
);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_FLAGS  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
  localparam logic [23:0] LAST_PAY  = 24'(IMAGE_BYTES - 1);
  localparam logic [23:0] LAST_FLAG = 24'(IMAGE_BYTES + FLAG_BYTES - 1);
  localparam logic [23:0] PAY_END   = 24'(IMAGE_BYTES);
  localparam logic [23:0] SPLIT_OFF = 24'(SPLIT_BYTES);

  logic [1:0]           state;
  logic [SLOT_BITS-1:0] slot;
  logic [23:0]          offset;
  logic [CNT_W-1:0]     settle_cnt;
  logic                 accept;
  logic                 payload_accept;
  logic                 settle_end;
  logic [23:0]          flag_idx;
  logic [21:0]          dest_addr;
  logic                 done_ok;

  // A byte in the reload cycle is dropped; the restarted request supersedes it.
  assign accept         = rd_valid && rd_ready && !reload;
  assign payload_accept = accept && (state == ST_LOAD);
  assign settle_end     = (state == ST_SETTLE) && (settle_cnt == SETTLE_LAST);
  assign flag_idx       = offset - PAY_END;

  // Address is forced to zero while idle so every output reads 0 out of reset.
  assign rd_addr = rd_valid ? (FLASH_BASE + (24'(slot) << SLOT_SHIFT) + offset) : 24'h0;

  // Payload offset to RAM address: lower part stays put, upper part is rebased.
  always_comb begin
    if (offset < SPLIT_OFF) dest_addr = DEST_LO_BASE + offset[21:0];
    else                    dest_addr = DEST_HI_BASE + 22'(offset - SPLIT_OFF);
  end

  // Sequencer: slot/offset tracking, flag capture, settle timer, ready flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_LOAD;
      slot       <= '0;
      offset     <= '0;
      settle_cnt <= '0;
      rd_valid   <= 1'b0;
      flags_out  <= '0;
      cart_ready <= 1'b0;
    end else if (reload) begin
      state      <= ST_LOAD;
      slot       <= index;
      offset     <= '0;
      settle_cnt <= '0;
      rd_valid   <= 1'b1;
      flags_out  <= '0;
      cart_ready <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          rd_valid <= 1'b1;
          if (accept) begin
            offset <= offset + 24'd1;
            if (offset == LAST_PAY) state <= ST_FLAGS;
          end
        end
        ST_FLAGS: begin
          if (accept) begin
            for (int k = 0; k < FLAG_BYTES; k++) begin
              if (flag_idx == 24'(k)) flags_out[8*k +: 8] <= rd_data;
            end
            offset <= offset + 24'd1;
            if (offset == LAST_FLAG) begin
              state    <= ST_SETTLE;
              rd_valid <= 1'b0;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_end) begin
            state      <= ST_DONE;
            cart_ready <= done_ok;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM write port: one registered write per accepted payload byte, never cancelled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_wren       <= 1'b0;
      load_address    <= '0;
      load_write_data <= '0;
    end else begin
      load_wren <= payload_accept;
      if (payload_accept) begin
        load_address    <= dest_addr;
        load_write_data <= rd_data;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] sum;
  logic [15:0] expected_sum;

  assign expected_sum = flags_out[8*FLAG_BYTES-1 -: 16];
  assign done_ok      = (sum == expected_sum);

  // Running payload sum and the error verdict taken when settle completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum        <= '0;
      load_error <= 1'b0;
    end else if (reload) begin
      sum        <= '0;
      load_error <= 1'b0;
    end else begin
      if (payload_accept) sum <= sum + 16'(rd_data);
      if (settle_end) load_error <= !done_ok;
    end
  end
`else
  assign done_ok    = 1'b1;
  assign load_error = 1'b0;
`endif

endmodule

// File: tb/tb_cart_image_loader.sv
// Bench for cart_image_loader: a transaction-level model (offset counter, expected write
// queue, settle countdown) is compared against the DUT every cycle, plus a vector table
// of load scenarios and directed sequences for reload, reset and checksum cases.
module tb_cart_image_loader;
  localparam int IB    = 16;
  localparam int SPLIT = 8;
  localparam int FB    = 4;
  localparam int S     = 20;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, reload;
  logic [3:0]  index;
  logic        rd_valid;
  logic [23:0] rd_addr;
  logic        rd_ready;
  logic [7:0]  rd_data;
  logic        load_wren;
  logic [21:0] load_address;
  logic [7:0]  load_write_data;
  logic [31:0] flags_out;
  logic        cart_ready, load_error;

  int checks = 0;
  int errors = 0;

  cart_image_loader #(
    .IMAGE_BYTES(IB), .SPLIT_BYTES(SPLIT), .DEST_LO_BASE(22'h0), .DEST_HI_BASE(22'h200000),
    .FLASH_BASE(24'h200000), .SLOT_SHIFT(18), .SLOT_BITS(4), .FLAG_BYTES(FB), .SETTLE_CYCLES(S)
  ) dut (
    .clock(clk), .reset(reset), .reload(reload), .index(index),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data),
    .load_wren(load_wren), .load_address(load_address), .load_write_data(load_write_data),
    .flags_out(flags_out), .cart_ready(cart_ready), .load_error(load_error)
  );

  always #5 clk = ~clk;

  // flash content control
  int rmode = 0;
  bit ck_mode = 1'b0;
  int corrupt_off = -1;
  int div_cnt = 0;

  // reference model state
  logic [3:0]  m_slot;
  int          m_off, m_settle;
  bit          m_active, m_start, m_wr, m_ready, m_err, m_done;
  logic [21:0] m_wr_addr;
  logic [7:0]  m_wr_data;
  logic [31:0] m_flags;
  logic [15:0] m_sum;
  int          cyc = 0, last_flag_cyc = 0, ready_rise_cyc = 0;
  bit          prev_ready = 1'b0;
  logic [21:0] wr_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    logic [7:0] b;
    int off;
    off = int'(a[17:0]);
    b = a[7:0];
    if (ck_mode && off == IB + 2) b = 8'h78;
    if (ck_mode && off == IB + 3) b = 8'h00;
    if (off == corrupt_off) b = b + 8'd1;
    return b;
  endfunction

  function automatic logic [23:0] exp_rd_addr();
    return 24'(32'h200000 + (int'(m_slot) << 18) + m_off);
  endfunction

  task automatic m_init();
    m_slot = 0; m_off = 0; m_settle = 0;
    m_active = 0; m_start = 1; m_wr = 0; m_ready = 0; m_err = 0; m_done = 0;
    m_wr_addr = 0; m_wr_data = 0; m_flags = 0; m_sum = 0;
    wr_log.delete();
  endtask

  task automatic m_finish();
    logic [15:0] exp_sum;
    exp_sum = m_flags[31:16];
    m_ready = CK ? (m_sum == exp_sum) : 1'b1;
    m_err   = CK ? (m_sum != exp_sum) : 1'b0;
    m_done  = 1'b1;
  endtask

  // model update on each active edge (or asynchronous reset)
  initial begin
    m_init();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_init();
      end else begin
        cyc++;
        m_wr = 1'b0;
        if (reload) begin
          m_slot = index; m_off = 0; m_flags = 0; m_ready = 0; m_err = 0; m_sum = 0;
          m_settle = 0; m_active = 1; m_start = 0; m_done = 0;
          wr_log.delete();
        end else if (m_start) begin
          m_start = 0; m_active = 1;
        end else if (m_active && rd_ready) begin
          if (m_off < IB) begin
            m_wr = 1'b1;
            m_wr_addr = (m_off < SPLIT) ? 22'(m_off) : 22'(32'h200000 + m_off - SPLIT);
            m_wr_data = rd_data;
            m_sum = m_sum + 16'(rd_data);
          end else begin
            m_flags[8*(m_off-IB) +: 8] = rd_data;
          end
          m_off++;
          if (m_off == IB + FB) begin
            m_active = 0; m_settle = S + 1; last_flag_cyc = cyc;
          end
        end else if (m_settle > 0) begin
          m_settle--;
          if (m_settle == 0) m_finish();
        end
      end
    end
  end

  // flash responder, driven on the falling edge
  initial begin
    rd_ready = 1'b0;
    rd_data = 8'h00;
    forever begin
      @(negedge clk);
      rd_ready = 1'b0;
      rd_data = 8'($urandom);
      if (rd_valid) begin
        bit go;
        case (rmode)
          0:       go = 1'b1;
          1:       go = (div_cnt % 4 == 3);
          default: go = ($urandom_range(0, 2) == 0);
        endcase
        div_cnt++;
        if (go) begin
          rd_ready = 1'b1;
          rd_data = flash_byte(rd_addr);
        end
      end else if (rmode == 2) begin
        rd_ready = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("rd_valid", rd_valid, m_active);
      if (m_active) chk("rd_addr", rd_addr, exp_rd_addr());
      chk("load_wren", load_wren, m_wr);
      if (m_wr) begin
        chk("load_address", load_address, m_wr_addr);
        chk("load_write_data", load_write_data, m_wr_data);
      end
      chk("flags_out", flags_out, m_flags);
      chk("cart_ready", cart_ready, m_ready);
      chk("load_error", load_error, m_err);
      if (load_wren) wr_log.push_back(load_address);
      if (cart_ready && !prev_ready) ready_rise_cyc = cyc;
      prev_ready = cart_ready;
    end
  end

  task automatic pulse_reload(input logic [3:0] s);
    reload = 1'b1;
    index = s;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (m_done) break;
    end
    checks++;
    if (!m_done) begin
      errors++;
      $display("FAIL load_timeout actual=not_done expected=done t=%0t", $time);
    end
  endtask

  task automatic wait_off(input int target);
    for (int i = 0; i < 500; i++) begin
      if (m_off == target) break;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [3:0]  idx;
    int          mode;
    logic [23:0] exp_addr;
    logic [31:0] exp_flags;
  } vec_t;
  vec_t vt[4];

  initial begin
    vt[0] = '{idx: 4'd0,  mode: 0, exp_addr: 24'h200000, exp_flags: 32'h00781110};
    vt[1] = '{idx: 4'd3,  mode: 1, exp_addr: 24'h2C0000, exp_flags: 32'h00781110};
    vt[2] = '{idx: 4'd15, mode: 2, exp_addr: 24'h5C0000, exp_flags: 32'h00781110};
    vt[3] = '{idx: 4'd7,  mode: 2, exp_addr: 24'h3C0000, exp_flags: 32'h00781110};

    reset = 1'b1; reload = 1'b0; index = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_wren", load_wren, 1'b0);
    chk("rst_ready", cart_ready, 1'b0);
    chk("rst_flags", flags_out, 32'h0);
    reset = 1'b0;

    // automatic load from slot 0, flash ready every cycle
    wait_done();
    chk("t1_flags", flags_out, 32'h13121110);
    chk("t1_wr_count", wr_log.size(), 16);
    if (wr_log.size() == 16) begin
      chk("t1_wr0", wr_log[0], 22'h000000);
      chk("t1_wr7", wr_log[7], 22'h000007);
      chk("t1_wr8", wr_log[8], 22'h200000);
      chk("t1_wr15", wr_log[15], 22'h200007);
    end

    // reload to slot 3 at offset 5, colliding with an accepted byte
    ck_mode = 1'b1;
    pulse_reload(4'd0);
    wait_off(5);
    pulse_reload(4'd3);
    chk("t2_addr", rd_addr, 24'h2C0000);
    chk("t2_flags_clr", flags_out, 32'h0);
    chk("t5_drop_wr", load_wren, 1'b0);
    wait_done();
    chk("t2_wr_count", wr_log.size(), 16);
    chk("t2_settle_lat", ready_rise_cyc - last_flag_cyc, S + 1);
    chk("t2_ready", cart_ready, 1'b1);

    // vector table: slot and flash pacing variants
    for (int i = 0; i < 4; i++) begin
      rmode = vt[i].mode;
      pulse_reload(vt[i].idx);
      chk("tbl_addr", rd_addr, vt[i].exp_addr);
      wait_done();
      chk("tbl_wr_count", wr_log.size(), 16);
      chk("tbl_flags", flags_out, vt[i].exp_flags);
      chk("tbl_ready", cart_ready, 1'b1);
      chk("tbl_error", load_error, 1'b0);
    end

    // random reload interruptions under random flash pacing
    for (int r = 0; r < 4; r++) begin
      rmode = 2;
      pulse_reload(4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 25)) @(negedge clk);
      pulse_reload(4'($urandom_range(0, 15)));
      wait_done();
      chk("rnd_wr_count", wr_log.size(), 16);
    end

    // asynchronous reset in the middle of the flag bytes
    rmode = 0;
    pulse_reload(4'd5);
    wait_off(IB + 2);
    #2 reset = 1'b1;
    #1;
    chk("t4_rd_valid", rd_valid, 1'b0);
    chk("t4_rd_addr", rd_addr, 24'h0);
    chk("t4_wren", load_wren, 1'b0);
    chk("t4_address", load_address, 22'h0);
    chk("t4_wdata", load_write_data, 8'h0);
    chk("t4_flags", flags_out, 32'h0);
    chk("t4_ready", cart_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t4_restart_valid", rd_valid, 1'b1);
    chk("t4_restart_addr", rd_addr, 24'h200000);
    wait_done();
    chk("t4_wr_count", wr_log.size(), 16);
    chk("t4_ready", cart_ready, 1'b1);

    // checksum: good image, then one corrupted payload byte
    pulse_reload(4'd0);
    wait_done();
    chk("t6_good_ready", cart_ready, 1'b1);
    chk("t6_good_error", load_error, 1'b0);
    corrupt_off = 5;
    pulse_reload(4'd0);
    wait_done();
    chk("t6_bad_ready", cart_ready, CK ? 1'b0 : 1'b1);
    chk("t6_bad_error", load_error, CK ? 1'b1 : 1'b0);
    corrupt_off = -1;

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
